// File: rtl/rom_loader_if.sv
// Bus bundle between rom_loader, the external ROM pins and the block RAM sinks.
// ROM_LOADER_CHECKSUM_EN adds the sum/sum_ok outputs.
interface rom_loader_if #(
  parameter int ROM_AW = 19,
  parameter int NREG   = 8
);
  logic              start;
  logic [ROM_AW-1:0] run_addr;
  logic [7:0]        rom_d;
  logic [ROM_AW-1:0] rom_a;
  logic              rom_oe_n;
  logic [ROM_AW-1:0] dl_addr;
  logic [7:0]        dl_data;
  logic [NREG-1:0]   dl_we;
  logic              busy;
  logic              done;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0]       sum;
  logic              sum_ok;
`endif

  modport master (
    input  start, run_addr, rom_d,
    output rom_a, rom_oe_n, dl_addr, dl_data, dl_we, busy, done
`ifdef ROM_LOADER_CHECKSUM_EN
    , output sum, sum_ok
`endif
  );

  modport slave (
    output start, run_addr, rom_d,
    input  rom_a, rom_oe_n, dl_addr, dl_data, dl_we, busy, done
`ifdef ROM_LOADER_CHECKSUM_EN
    , input sum, sum_ok
`endif
  );
endinterface

// File: rtl/rom_loader.sv
// Boot-time ROM image loader: copies LOAD_LEN bytes into region-decoded RAMs, then
// passes the core's ROM address through. Optional checksum via ROM_LOADER_CHECKSUM_EN.
module rom_loader #(
  parameter int                     ROM_AW      = 19,
  parameter int                     LOAD_LEN    = 131072,
  parameter int                     WAIT_CYC    = 1,
  parameter int                     NREG        = 8,
  parameter logic [NREG*ROM_AW-1:0] REGION_BASE = '0,
  parameter logic [NREG*ROM_AW-1:0] REGION_MASK = '0,
  parameter bit                     AUTOSTART   = 1'b1
`ifdef ROM_LOADER_CHECKSUM_EN
  , parameter logic [15:0]          EXPECT_SUM  = 16'h0000
`endif
) (
  input  logic        clk_6144,
  input  logic        n_reset,
  rom_loader_if.master bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADDR  = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int WW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [ROM_AW-1:0] LAST_ADDR = ROM_AW'(LOAD_LEN - 1);
  localparam logic [WW-1:0]     WAIT_INIT = WW'(WAIT_CYC - 1);

  logic [2:0]        r_state;
  logic [ROM_AW-1:0] r_addr;
  logic [WW-1:0]     r_wait;
  logic [7:0]        r_data;
  logic [NREG-1:0]   w_hit;
  logic              w_go;

  // A load begins from IDLE (start or autostart) or as a full reload from DONE.
  assign w_go = ((r_state == IDLE) && (bus.start || AUTOSTART)) ||
                ((r_state == DONE) && bus.start);

  // Descending scan so the lowest-index matching region is the one left set.
  always_comb begin
    w_hit = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if ((r_addr & REGION_MASK[i*ROM_AW +: ROM_AW]) == REGION_BASE[i*ROM_AW +: ROM_AW]) begin
        w_hit    = '0;
        w_hit[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_6144 or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wait  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_go) r_state <= ADDR;
        end
        ADDR: begin
          r_wait  <= WAIT_INIT;
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_wait == '0) begin
            r_data  <= bus.rom_d;
            r_state <= WRITE;
          end else begin
            r_wait <= r_wait - WW'(1);
          end
        end
        WRITE: begin
          if (r_addr == LAST_ADDR) begin
            r_addr  <= '0;
            r_state <= DONE;
          end else begin
            r_addr  <= r_addr + ROM_AW'(1);
            r_state <= ADDR;
          end
        end
        DONE: begin
          if (w_go) begin
            r_addr  <= '0;
            r_state <= ADDR;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // After the load the core drives the ROM directly, with no added latency.
  assign bus.rom_a    = (r_state == DONE) ? bus.run_addr : r_addr;
  assign bus.rom_oe_n = (r_state == IDLE);
  assign bus.dl_addr  = r_addr;
  assign bus.dl_data  = r_data;
  assign bus.dl_we    = (r_state == WRITE) ? w_hit : '0;
  assign bus.busy     = (r_state == ADDR) || (r_state == WAIT) || (r_state == WRITE);
  assign bus.done     = (r_state == DONE);

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] r_sum;

  // Every copied byte counts, including ones no region claims.
  always_ff @(posedge clk_6144 or negedge n_reset) begin
    if (!n_reset) begin
      r_sum <= '0;
    end else if (w_go) begin
      r_sum <= '0;
    end else if (r_state == WRITE) begin
      r_sum <= r_sum + {8'h00, r_data};
    end
  end

  assign bus.sum    = r_sum;
  assign bus.sum_ok = (r_sum == EXPECT_SUM) && (r_state == DONE);
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Directed self-checking bench for rom_loader (16-byte image, two regions, 2-cycle ROM wait).
// Two instances: regions 0x00-07/0x08-0F, and a narrowed region1 that only hits 0x08.
module tb_rom_loader;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    logic [1:0] we;
    int         cyc;
  } ent_t;

  logic clk;
  logic n_reset;
  int   cyc;
  int   total;
  int   bad;
  int   busyCnt;
  int   bothCnt;
  int   overlapCnt;
  ent_t q1[$];
  ent_t q2[$];

  rom_loader_if #(.ROM_AW(8), .NREG(2)) bus1 ();
  rom_loader_if #(.ROM_AW(8), .NREG(2)) bus2 ();

  rom_loader #(
    .ROM_AW(8), .LOAD_LEN(16), .WAIT_CYC(2), .NREG(2),
    .REGION_BASE({8'h08, 8'h00}), .REGION_MASK({8'hF8, 8'hF8}), .AUTOSTART(1'b1)
`ifdef ROM_LOADER_CHECKSUM_EN
    , .EXPECT_SUM(16'h0578)
`endif
  ) dut (
    .clk_6144(clk), .n_reset(n_reset), .bus(bus1.master)
  );

  rom_loader #(
    .ROM_AW(8), .LOAD_LEN(16), .WAIT_CYC(2), .NREG(2),
    .REGION_BASE({8'h08, 8'h00}), .REGION_MASK({8'hFF, 8'hF8}), .AUTOSTART(1'b1)
`ifdef ROM_LOADER_CHECKSUM_EN
    , .EXPECT_SUM(16'h0579)
`endif
  ) dut2 (
    .clk_6144(clk), .n_reset(n_reset), .bus(bus2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: data for the presented address appears one clock later.
  always @(posedge clk) begin
    bus1.rom_d <= bus1.rom_a ^ 8'h5A;
    bus2.rom_d <= bus2.rom_a ^ 8'h5A;
  end

  initial begin
    busyCnt = 0;
    bothCnt = 0;
    overlapCnt = 0;
  end

  always @(negedge clk) begin
    if (bus1.dl_we != 2'b00) q1.push_back('{bus1.dl_addr, bus1.dl_data, bus1.dl_we, cyc});
    if (bus2.dl_we != 2'b00) q2.push_back('{bus2.dl_addr, bus2.dl_data, bus2.dl_we, cyc});
    if (bus1.busy) busyCnt = busyCnt + 1;
    if (bus1.dl_we == 2'b11 || bus2.dl_we == 2'b11) bothCnt = bothCnt + 1;
    if ((bus1.busy && bus1.done) || (bus2.busy && bus2.done)) overlapCnt = overlapCnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s);
    bus1.start = s;
    bus2.start = s;
  endtask

  task automatic waitDone(input int c0, input string tg);
    int k;
    k = 0;
    while (!bus1.done && k < 300) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tg, "_doneSeen"}, {31'b0, bus1.done}, 32'd1);
    checkOutput({tg, "_doneAt"}, cyc - c0, 32'd65);
  endtask

  task automatic checkLoad(input string tg, input int base);
    logic [7:0] a;
    checkOutput({tg, "_count"}, q1.size() - base, 32'd16);
    for (int i = 0; i < 16 && base + i < q1.size(); i++) begin
      a = 8'(i);
      checkOutput($sformatf("%s_addr%0d", tg, i), {24'b0, q1[base+i].a}, {24'b0, a});
      checkOutput($sformatf("%s_data%0d", tg, i), {24'b0, q1[base+i].d}, {24'b0, a ^ 8'h5A});
      checkOutput($sformatf("%s_we%0d", tg, i), {30'b0, q1[base+i].we}, (i < 8) ? 32'd1 : 32'd2);
      if (i > 0)
        checkOutput($sformatf("%s_gap%0d", tg, i), q1[base+i].cyc - q1[base+i-1].cyc, 32'd4);
    end
  endtask

  task automatic checkNarrow(input string tg, input int base);
    checkOutput({tg, "_count"}, q2.size() - base, 32'd9);
    if (q2.size() - base == 9) begin
      checkOutput({tg, "_addr7"}, {24'b0, q2[base+7].a}, 32'h07);
      checkOutput({tg, "_we7"}, {30'b0, q2[base+7].we}, 32'd1);
      checkOutput({tg, "_addr8"}, {24'b0, q2[base+8].a}, 32'h08);
      checkOutput({tg, "_we8"}, {30'b0, q2[base+8].we}, 32'd2);
    end
  endtask

  initial begin
    int c0;
    int b0;
    int base1;
    int base2;
    int k;
    total = 0;
    bad = 0;
    n_reset = 1'b0;
    applyStimulus(1'b0);
    bus1.run_addr = 8'h00;
    bus2.run_addr = 8'h00;
    repeat (3) @(negedge clk);

    checkOutput("rst_oe_n", {31'b0, bus1.rom_oe_n}, 32'd1);
    checkOutput("rst_busy", {31'b0, bus1.busy}, 32'd0);
    checkOutput("rst_done", {31'b0, bus1.done}, 32'd0);
    checkOutput("rst_we", {30'b0, bus1.dl_we}, 32'd0);
    checkOutput("rst_data", {24'b0, bus1.dl_data}, 32'd0);
    checkOutput("rst_rom_a", {24'b0, bus1.rom_a}, 32'd0);

    // Basic autostarted load and per-byte timing.
    base1 = q1.size();
    base2 = q2.size();
    b0 = busyCnt;
    n_reset = 1'b1;
    c0 = cyc;
    waitDone(c0, "load");
    checkOutput("load_busyCycles", busyCnt - b0, 32'd64);
    checkLoad("load", base1);
    checkNarrow("narrow", base2);

    // Run-time pass-through.
    bus1.run_addr = 8'hA5;
    #1;
    checkOutput("pass_rom_a", {24'b0, bus1.rom_a}, 32'hA5);
    checkOutput("pass_oe_n", {31'b0, bus1.rom_oe_n}, 32'd0);
    checkOutput("pass_we", {30'b0, bus1.dl_we}, 32'd0);
    checkOutput("pass_busy", {31'b0, bus1.busy}, 32'd0);
    bus1.run_addr = 8'h3C;
    #1;
    checkOutput("pass_rom_a2", {24'b0, bus1.rom_a}, 32'h3C);
`ifdef ROM_LOADER_CHECKSUM_EN
    checkOutput("cks_sum", {16'b0, bus1.sum}, 32'h0578);
    checkOutput("cks_ok", {31'b0, bus1.sum_ok}, 32'd1);
    checkOutput("cks_bad_ok", {31'b0, bus2.sum_ok}, 32'd0);
`endif

    // Restart from DONE: done drops next clock and a full reload follows.
    @(negedge clk);
    base1 = q1.size();
    base2 = q2.size();
    b0 = busyCnt;
    c0 = cyc;
    applyStimulus(1'b1);
    @(negedge clk);
    applyStimulus(1'b0);
    checkOutput("restart_doneLow", {31'b0, bus1.done}, 32'd0);
    checkOutput("restart_busy", {31'b0, bus1.busy}, 32'd1);
    checkOutput("restart_rom_a", {24'b0, bus1.rom_a}, 32'd0);
`ifdef ROM_LOADER_CHECKSUM_EN
    checkOutput("restart_cksOk", {31'b0, bus1.sum_ok}, 32'd0);
`endif
    waitDone(c0, "reload");
    checkOutput("reload_busyCycles", busyCnt - b0, 32'd64);
    checkLoad("reload", base1);
    checkNarrow("renarrow", base2);
`ifdef ROM_LOADER_CHECKSUM_EN
    checkOutput("reload_sum", {16'b0, bus1.sum}, 32'h0578);
    checkOutput("reload_cksOk", {31'b0, bus1.sum_ok}, 32'd1);
`endif

    // Reset asserted during byte 5, then reload with an ignored mid-load start.
    @(negedge clk);
    applyStimulus(1'b1);
    @(negedge clk);
    applyStimulus(1'b0);
    k = 0;
    while (bus1.dl_addr != 8'h05 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("mid_reachByte5", {24'b0, bus1.dl_addr}, 32'h05);
    n_reset = 1'b0;
    #1;
    checkOutput("mid_rst_busy", {31'b0, bus1.busy}, 32'd0);
    checkOutput("mid_rst_we", {30'b0, bus1.dl_we}, 32'd0);
    checkOutput("mid_rst_oe_n", {31'b0, bus1.rom_oe_n}, 32'd1);
    checkOutput("mid_rst_rom_a", {24'b0, bus1.rom_a}, 32'd0);
    checkOutput("mid_rst_data", {24'b0, bus1.dl_data}, 32'd0);
    checkOutput("mid_rst_done", {31'b0, bus1.done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    base1 = q1.size();
    n_reset = 1'b1;
    c0 = cyc;
    repeat (10) @(negedge clk);
    applyStimulus(1'b1);
    @(negedge clk);
    applyStimulus(1'b0);
    waitDone(c0, "afterRst");
    checkLoad("afterRst", base1);

    checkOutput("neverBothWe", bothCnt, 32'd0);
    checkOutput("neverBusyAndDone", overlapCnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Parametrised boot-time loader. Copies a contiguous image from the external parallel ROM into up to NREG internal block RAMs, selected by address-range decode.
- Sits between the external ROM pins and the game core.
- While loading, it owns the ROM address bus and holds the CPUs in reset through `done`.
- After loading, it passes the core's run-time ROM address straight through.
- Generalises the fixed single-counter download: configurable ROM access wait, region table, restart, and optional checksum.

Parameters:
- ROM_AW, 19, external ROM address width.
- LOAD_LEN, 131072, number of bytes copied, starting at address 0. Range 1..2^ROM_AW.
- WAIT_CYC, 1, clocks the address is held before `rom_d` is sampled. Must be ≥1.
- NREG, 8, number of destination regions.
- REGION_BASE, 0, packed NREG*ROM_AW. Region i base is bits [i*ROM_AW +: ROM_AW].
- REGION_MASK, 0, packed NREG*ROM_AW. Region i hits when (addr & mask_i) == base_i.
- AUTOSTART, 1, begin loading automatically on the first clock after reset release.

Ports:
- clk_6144  in  1  loader clock.
- n_reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; starts or restarts a load.
- run_addr  in  ROM_AW  core ROM address, used once `done` is high.
- rom_d  in  8  external ROM data.
- rom_a  out  ROM_AW  external ROM address.
- rom_oe_n  out  1  external ROM output enable, active low.
- dl_addr  out  ROM_AW  current byte address; sinks use its low bits.
- dl_data  out  8  byte being written.
- dl_we  out  NREG  one-hot write strobe, one bit per region.
- busy  out  1  a load is in progress.
- done  out  1  image complete; used as the CPU reset release.

Behaviour:
- Reset values (asynchronous, n_reset low):
  - state=IDLE, load address=0, wait counter=0.
  - dl_data=0, dl_we=0, busy=0, done=0, rom_oe_n=1.
  - rom_a=0 (load address).
- States: IDLE, ADDR, WAIT, WRITE, DONE.
- IDLE:
  - Go to ADDR on `start`.
  - If AUTOSTART=1, also go to ADDR on the first clock after reset release.
  - rom_oe_n=1.
- ADDR:
  - rom_a = load address (registered). busy=1, rom_oe_n=0.
  - Wait counter loads WAIT_CYC-1. Next state is WAIT.
- WAIT:
  - Counter decrements each clock.
  - On the clock where the counter reads 0, capture `rom_d` into `dl_data` and go to WRITE.
  - This gives exactly WAIT_CYC WAIT cycles.
- WRITE:
  - dl_we[i]=1 for exactly one cycle, where i is the lowest-index region hit by the load address.
  - No hit: dl_we stays 0 and the byte is discarded.
  - dl_addr = load address throughout the byte.
  - If load address == LOAD_LEN-1: go to DONE, load address returns to 0.
  - Otherwise increment the load address and go to ADDR.
- Throughput: one byte per WAIT_CYC+2 clocks. Full load = LOAD_LEN*(WAIT_CYC+2) clocks.
- DONE:
  - done=1, busy=0, dl_we=0, rom_oe_n=0.
  - rom_a = run_addr, combinational mux with no added latency.
  - `start` in DONE: done drops next clock, load address is cleared, go to ADDR (full reload).
- `start` while busy: ignored.
- Reset mid-load: immediate return to IDLE. Partial RAM contents are not cleared. With AUTOSTART=1 the load restarts from 0.
- `done` and `busy` are never high together. `done` rises on the clock after the final WRITE cycle.
- Overlapping regions resolve by priority: lowest index wins, only one dl_we bit ever set.
- LOAD_LEN = 2^ROM_AW: the final-byte compare must be full-width, with no counter overflow before DONE.

Optional Feature:
- Macro ROM_LOADER_CHECKSUM_EN.
- When defined, adds:
  - parameter EXPECT_SUM (16 bits, default 0);
  - output sum (16 bits);
  - output sum_ok (1 bit).
- sum is cleared on entry to ADDR from IDLE or DONE. Each WRITE cycle adds the byte, zero-extended, modulo 2^16, whether or not a region hit.
- sum_ok = (sum == EXPECT_SUM) and done. It is 0 in reset and while loading.
- When undefined, none of these exist and no adder is synthesised.

Test Plan:
- Common setup for all scenarios:
  - ROM_AW=8, LOAD_LEN=16, WAIT_CYC=2, NREG=2, AUTOSTART=1.
  - Region0 base 0x00 mask 0xF8; region1 base 0x08 mask 0xF8.
  - ROM model: rom_d = addr ^ 0x5A, valid 1 clock after rom_a changes.
- Scenario 1 (basic load): release reset.
  - 8 pulses on dl_we[0] with addresses 0x00..0x07 and data 0x5A..0x5D,0x5E..0x5D^… (= addr^0x5A).
  - 8 pulses on dl_we[1] with addresses 0x08..0x0F.
  - done rises at clock 64±1 after reset release.
- Scenario 2 (byte timing): check the per-byte sequence.
  - Exactly 4 clocks between successive dl_we pulses.
  - dl_we never has both bits set.
  - busy=1 throughout the load.
- Scenario 3 (run-time pass-through): after done, drive run_addr=0xA5.
  - rom_a=0xA5 in the same cycle. rom_oe_n=0. dl_we=0.
- Scenario 4 (reset and start rules):
  - Assert n_reset low during byte 5: outputs return to reset values asynchronously.
  - After release, the load restarts at address 0x00.
  - A `start` pulse mid-load is ignored: byte count is unchanged, done at the same clock.
- Scenario 5 (restart and no-hit): pulse `start` in DONE.
  - done falls next clock and a full 16-byte reload follows.
  - Shrink region1 mask to 0xFF, base 0x08: only bytes 0x00..0x08 produce strobes.
- Scenario 6 (ROM_LOADER_CHECKSUM_EN defined, EXPECT_SUM = sum of (i^0x5A) for i=0..15):
  - sum_ok=1 after done.
  - With EXPECT_SUM+1: sum_ok=0.
